// File: rtl/fft_bitrev_buf_if.sv
// rtl/fft_bitrev_buf_if.sv - sample-in / butterfly-pair-out handshake bundle
interface fft_bitrev_buf_if #(
  parameter int FFT_DATA_WD = 10
);
  logic signed [FFT_DATA_WD-1:0] fft_in_re;
  logic signed [FFT_DATA_WD-1:0] fft_in_im;
  logic                          fft_in_valid;
  logic                          fft_in_ready;
  logic signed [FFT_DATA_WD-1:0] fft_dout_1_re;
  logic signed [FFT_DATA_WD-1:0] fft_dout_1_im;
  logic signed [FFT_DATA_WD-1:0] fft_dout_2_re;
  logic signed [FFT_DATA_WD-1:0] fft_dout_2_im;
  logic                          fft_out_valid;
  logic                          fft_out_ready;
  logic                          fft_out_first;
  logic                          fft_out_last;

  // Buffer side: consumes samples, produces operand pairs.
  modport slave (
    input  fft_in_re, fft_in_im, fft_in_valid, fft_out_ready,
    output fft_in_ready, fft_dout_1_re, fft_dout_1_im, fft_dout_2_re, fft_dout_2_im,
           fft_out_valid, fft_out_first, fft_out_last
  );

  // Surrounding logic: supplies samples, consumes operand pairs.
  modport master (
    output fft_in_re, fft_in_im, fft_in_valid, fft_out_ready,
    input  fft_in_ready, fft_dout_1_re, fft_dout_1_im, fft_dout_2_re, fft_dout_2_im,
           fft_out_valid, fft_out_first, fft_out_last
  );
endinterface

// File: rtl/fft_bitrev_buf.sv
// rtl/fft_bitrev_buf.sv - ping-pong 64-point bit-reversal buffer feeding radix-2 stage 1
module fft_bitrev_buf #(
  parameter int FFT_DATA_WD = 10,
  parameter int FFT_PTS     = 64
) (
  input  logic           clk,
  input  logic           rst,
  fft_bitrev_buf_if.slave bus
);

  localparam int AW = 6;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD} state_t;

  logic signed [FFT_DATA_WD-1:0] mem_re_q [2][FFT_PTS];
  logic signed [FFT_DATA_WD-1:0] mem_im_q [2][FFT_PTS];

  logic          wr_bank_q, wr_bank_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [1:0]    full_q, full_d;
  logic          rd_bank_q, rd_bank_d;
  logic [4:0]    rd_k_q, rd_k_d;
  state_t        state_q, state_d;

  logic signed [FFT_DATA_WD-1:0] d1_re_q, d1_re_d, d1_im_q, d1_im_d;
  logic signed [FFT_DATA_WD-1:0] d2_re_q, d2_re_d, d2_im_q, d2_im_d;
  logic first_q, first_d, last_q, last_d;

  logic          in_accept, wr_done, consume, frame_end, avail, load;
  logic          next_bank;
  logic [4:0]    next_k;
  logic [AW-1:0] addr_1, addr_2;

  function automatic logic [AW-1:0] bitrev6(input logic [AW-1:0] a);
    logic [AW-1:0] r;
    for (int i = 0; i < AW; i++) r[i] = a[AW-1-i];
    return r;
  endfunction

  assign bus.fft_in_ready  = ~(full_q[0] & full_q[1]);
  assign bus.fft_out_valid = (state_q != S_IDLE);
  assign bus.fft_dout_1_re = d1_re_q;
  assign bus.fft_dout_1_im = d1_im_q;
  assign bus.fft_dout_2_re = d2_re_q;
  assign bus.fft_dout_2_im = d2_im_q;
  assign bus.fft_out_first = first_q;
  assign bus.fft_out_last  = last_q;

  // Write side plus read-side sequencing: bank bookkeeping, pair selection, state.
  always_comb begin
    in_accept = bus.fft_in_valid & bus.fft_in_ready;
    wr_done   = in_accept && (wr_addr_q == AW'(FFT_PTS - 1));
    wr_addr_d = in_accept ? wr_addr_q + 6'd1 : wr_addr_q;
    wr_bank_d = wr_done ? ~wr_bank_q : wr_bank_q;

    consume   = (state_q != S_IDLE) && bus.fft_out_ready;
    frame_end = consume && (rd_k_q == 5'd31);
    next_bank = frame_end ? ~rd_bank_q : rd_bank_q;
    // A bank finishing its last write this cycle counts as ready: pair 0 only
    // needs addresses 0 and 32, which are already stored.
    avail     = full_q[next_bank] | (wr_done && (wr_bank_q == next_bank));
    load      = ((state_q == S_IDLE) && avail) || (consume && !frame_end) || (frame_end && avail);
    next_k    = ((state_q == S_IDLE) || frame_end) ? 5'd0 : rd_k_q + 5'd1;
    addr_1    = bitrev6({next_k, 1'b0});
    addr_2    = bitrev6({next_k, 1'b1});

    full_d = full_q;
    if (frame_end) full_d[rd_bank_q] = 1'b0;
    if (wr_done)   full_d[wr_bank_q] = 1'b1;
    rd_bank_d = next_bank;

    rd_k_d  = rd_k_q;
    d1_re_d = d1_re_q;
    d1_im_d = d1_im_q;
    d2_re_d = d2_re_q;
    d2_im_d = d2_im_q;
    first_d = first_q;
    last_d  = last_q;
    if (load) begin
      rd_k_d  = next_k;
      d1_re_d = mem_re_q[next_bank][addr_1];
      d1_im_d = mem_im_q[next_bank][addr_1];
      d2_re_d = mem_re_q[next_bank][addr_2];
      d2_im_d = mem_im_q[next_bank][addr_2];
      first_d = (next_k == 5'd0);
      last_d  = (next_k == 5'd31);
    end else if (frame_end) begin
      first_d = 1'b0;
      last_d  = 1'b0;
    end

    state_d = state_q;
    case (state_q)
      S_IDLE: if (avail) state_d = S_RUN;
      S_RUN, S_HOLD: begin
        if (!bus.fft_out_ready)     state_d = S_HOLD;
        else if (frame_end && !avail) state_d = S_IDLE;
        else                        state_d = S_RUN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and output registers; reset drops every frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank_q <= 1'b0;
      wr_addr_q <= '0;
      full_q    <= '0;
      rd_bank_q <= 1'b0;
      rd_k_q    <= '0;
      state_q   <= S_IDLE;
      d1_re_q   <= '0;
      d1_im_q   <= '0;
      d2_re_q   <= '0;
      d2_im_q   <= '0;
      first_q   <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      wr_bank_q <= wr_bank_d;
      wr_addr_q <= wr_addr_d;
      full_q    <= full_d;
      rd_bank_q <= rd_bank_d;
      rd_k_q    <= rd_k_d;
      state_q   <= state_d;
      d1_re_q   <= d1_re_d;
      d1_im_q   <= d1_im_d;
      d2_re_q   <= d2_re_d;
      d2_im_q   <= d2_im_d;
      first_q   <= first_d;
      last_q    <= last_d;
    end
  end

  // Sample storage; contents are left as-is on reset since the full flags gate use.
  always_ff @(posedge clk) begin
    if (!rst && in_accept) begin
      mem_re_q[wr_bank_q][wr_addr_q] <= bus.fft_in_re;
      mem_im_q[wr_bank_q][wr_addr_q] <= bus.fft_in_im;
    end
  end

endmodule

// File: tb/tb_fft_bitrev_buf.sv
// tb/tb_fft_bitrev_buf.sv - randomized bench for fft_bitrev_buf against a bit-reversal frame model
module tb_fft_bitrev_buf;

  localparam int W = 10;
  typedef logic [2*W-1:0] samp_t;
  typedef logic [4*W+1:0] pair_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fft_bitrev_buf_if #(.FFT_DATA_WD(W)) ifc ();

  fft_bitrev_buf #(.FFT_DATA_WD(W), .FFT_PTS(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  int    n_vec = 0;
  int    n_err = 0;
  samp_t in_q[$];
  pair_t exp_q[$];
  int    acc_count  = 0;
  int    pairs_done = 0;
  bit    stall_mode = 0;
  bit    have_prev  = 0;
  bit    snd_done   = 0;
  pair_t prev_word;
  logic  prev_valid, prev_ready;
  pair_t cur_word;

  assign cur_word = {ifc.fft_dout_1_re, ifc.fft_dout_1_im, ifc.fft_dout_2_re, ifc.fft_dout_2_im,
                     ifc.fft_out_first, ifc.fft_out_last};

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Address reversal computed arithmetically, lowest bit first.
  function automatic int bitrev6(input int a);
    int r = 0;
    int v = a;
    repeat (6) begin
      r = r * 2 + v % 2;
      v = v / 2;
    end
    return r;
  endfunction

  function automatic void build_frame();
    samp_t fr[64];
    for (int n = 0; n < 64; n++) fr[n] = in_q.pop_front();
    for (int k = 0; k < 32; k++)
      exp_q.push_back({fr[bitrev6(2*k)], fr[bitrev6(2*k+1)], k == 0, k == 31});
  endfunction

  // Monitor: output ordering, stall stability, availability, and input capture.
  always @(negedge clk) begin
    if (rst) begin
      in_q.delete();
      exp_q.delete();
      have_prev = 0;
    end else begin
      if (have_prev && prev_valid && !prev_ready) begin
        check("hold_valid", ifc.fft_out_valid, 1);
        check("hold_data", cur_word, prev_word);
      end
      if (exp_q.size() > 0) check("no_bubble", ifc.fft_out_valid, 1);
      if (ifc.fft_out_valid && ifc.fft_out_ready) begin
        if (exp_q.size() == 0) check("unexpected_pair", 1, 0);
        else begin
          check("pair", cur_word, exp_q.pop_front());
          pairs_done++;
        end
      end
      if (ifc.fft_in_valid && ifc.fft_in_ready) begin
        in_q.push_back({ifc.fft_in_re, ifc.fft_in_im});
        acc_count++;
        if (in_q.size() == 64) build_frame();
      end
      prev_word  = cur_word;
      prev_valid = ifc.fft_out_valid;
      prev_ready = ifc.fft_out_ready;
      have_prev  = 1;
    end
  end

  // Random backpressure on the output side.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (stall_mode) ifc.fft_out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic send(input logic [W-1:0] re, input logic [W-1:0] im, input bit gaps);
    int b = 0;
    if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    ifc.fft_in_re    = re;
    ifc.fft_in_im    = im;
    ifc.fft_in_valid = 1'b1;
    @(negedge clk);
    while (!ifc.fft_in_ready && b < 3000) begin
      @(negedge clk);
      b++;
    end
    if (b >= 3000) check("in_timeout", 0, 1);
    @(posedge clk);
    #1;
    ifc.fft_in_valid = 1'b0;
  endtask

  task automatic send_frame(input int kind, input bit gaps, input int count);
    logic [W-1:0] re, im;
    for (int n = 0; n < count; n++) begin
      case (kind)
        0: begin re = W'(n); im = W'(-n); end
        1: begin re = W'($urandom); im = W'($urandom); end
        default: begin
          re = (n % 2) ? W'(511) : W'(-512);
          im = (n % 2) ? W'(-512) : W'(511);
        end
      endcase
      send(re, im, gaps);
    end
  endtask

  task automatic wait_drain();
    int b = 0;
    while ((exp_q.size() > 0 || ifc.fft_out_valid) && b < 4000) begin
      @(negedge clk);
      b++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    int base;
    int b;
    ifc.fft_in_valid  = 1'b0;
    ifc.fft_in_re     = '0;
    ifc.fft_in_im     = '0;
    ifc.fft_out_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_valid", ifc.fft_out_valid, 0);
    check("rst_in_ready", ifc.fft_in_ready, 1);
    check("rst_outs", cur_word, 0);

    // Ramp frame, continuous flow, exact first-pair latency and known values.
    @(posedge clk);
    #1;
    ifc.fft_out_ready = 1'b1;
    send_frame(0, 0, 64);
    @(negedge clk);
    check("first_lat", ifc.fft_out_valid, 1);
    check("ramp_pair0", cur_word, {W'(0), W'(0), W'(32), W'(-32), 1'b1, 1'b0});
    wait_drain();

    // Three frames against a blocked output: the third must be refused.
    @(posedge clk);
    #1;
    ifc.fft_out_ready = 1'b0;
    base = acc_count;
    snd_done = 0;
    fork
      begin
        send_frame(1, 0, 64);
        send_frame(1, 0, 64);
        send_frame(1, 0, 64);
        snd_done = 1;
      end
    join_none
    b = 0;
    while (acc_count < base + 128 && b < 3000) begin
      @(negedge clk);
      b++;
    end
    repeat (4) @(negedge clk);
    check("in_ready_full", ifc.fft_in_ready, 0);
    check("accept_stop", acc_count - base, 128);
    @(posedge clk);
    #1;
    ifc.fft_out_ready = 1'b1;
    b = 0;
    while (!snd_done && b < 3000) begin
      @(negedge clk);
      b++;
    end
    check("send3_done", snd_done, 1);
    wait_drain();

    // Random stalls and input gaps.
    @(posedge clk);
    #1;
    stall_mode = 1;
    send_frame(1, 1, 64);
    send_frame(1, 1, 64);
    send_frame(1, 1, 64);
    stall_mode = 0;
    @(posedge clk);
    #1;
    ifc.fft_out_ready = 1'b1;
    wait_drain();

    // Full-scale alternating extremes.
    send_frame(2, 1, 64);
    send_frame(2, 0, 64);
    wait_drain();

    // Reset with one full frame draining and a partial frame in the other bank.
    @(posedge clk);
    #1;
    ifc.fft_out_ready = 1'b0;
    send_frame(1, 0, 64);
    send_frame(1, 0, 40);
    ifc.fft_out_ready = 1'b1;
    base = pairs_done;
    b = 0;
    while (pairs_done < base + 10 && b < 500) begin
      @(posedge clk);
      #1;
      b++;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_valid", ifc.fft_out_valid, 0);
    check("midrst_in_ready", ifc.fft_in_ready, 1);
    check("midrst_flags", {ifc.fft_out_first, ifc.fft_out_last}, 0);
    @(posedge clk);
    #1;
    send_frame(0, 1, 64);
    @(negedge clk);
    check("post_rst_first", ifc.fft_out_first, 1);
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
